// File: rtl/reloj_bcd.sv
// reloj_bcd: 24-hour BCD wall clock with a one-second prescaler and hour/minute set buttons.
// Ports:
//   clk              system clock, all state changes on its rising edge
//   reset            asynchronous active-low reset
//   run              1 = timekeeping advances, 0 = prescaler and seconds frozen
//   btn_hora         raw push-button, increments hours
//   btn_min          raw push-button, increments minutes and restarts the second
//   hora_d, hora_u   BCD hour digits (00..23)
//   min_d, min_u     BCD minute digits (00..59)
//   dp_blink         1 during the first half of each second
//   tick_min         one-cycle pulse after every natural minute rollover
module reloj_bcd #(
    parameter int unsigned SEC_DIV     = 100_000_000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       btn_hora,
    input  logic       btn_min,
    output logic [3:0] hora_d,
    output logic [3:0] hora_u,
    output logic [3:0] min_d,
    output logic [3:0] min_u,
    output logic       dp_blink,
    output logic       tick_min
);

    localparam int unsigned PW = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SEC_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(SEC_DIV / 2);

    logic [SYNC_STAGES-1:0] sync_h, sync_m;
    logic                   prev_h, prev_m;
    logic [SYNC_STAGES:0]   ready;
    logic                   pulse_h, pulse_m;

    logic [PW-1:0] presc, presc_n;
    logic [5:0]    sec, sec_n;
    logic [3:0]    hd_n, hu_n, md_n, mu_n;
    logic          dp_n, tick_n;
    logic          tick_sec, min_carry, hour_carry;

    // Button synchronisers and edge detectors. 'ready' masks pulses until the
    // chain holds real samples, so a button held through reset release is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_h <= '0;
            sync_m <= '0;
            prev_h <= 1'b0;
            prev_m <= 1'b0;
            ready  <= '0;
        end else begin
            sync_h <= {sync_h[SYNC_STAGES-2:0], btn_hora};
            sync_m <= {sync_m[SYNC_STAGES-2:0], btn_min};
            prev_h <= sync_h[SYNC_STAGES-1];
            prev_m <= sync_m[SYNC_STAGES-1];
            ready  <= {ready[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign pulse_h = sync_h[SYNC_STAGES-1] & ~prev_h & ready[SYNC_STAGES];
    assign pulse_m = sync_m[SYNC_STAGES-1] & ~prev_m & ready[SYNC_STAGES];

    // Next-state: every digit settles in one edge, so no intermediate value shows.
    always_comb begin
        presc_n    = presc;
        sec_n      = sec;
        hd_n       = hora_d;
        hu_n       = hora_u;
        md_n       = min_d;
        mu_n       = min_u;
        tick_n     = 1'b0;
        hour_carry = 1'b0;
        tick_sec   = run && (presc == PRE_LAST);
        min_carry  = tick_sec && (sec == 6'd59);

        if (run) begin
            presc_n = tick_sec ? '0 : presc + PW'(1);
        end
        if (tick_sec) begin
            sec_n = min_carry ? 6'd0 : sec + 6'd1;
        end

        // A press and a natural carry in the same cycle advance minutes once;
        // the press wins, so no hour carry and no tick_min.
        if (pulse_m || min_carry) begin
            if (min_u == 4'd9) begin
                mu_n = 4'd0;
                md_n = (min_d == 4'd5) ? 4'd0 : min_d + 4'd1;
            end else begin
                mu_n = min_u + 4'd1;
            end
            if (!pulse_m) begin
                tick_n     = 1'b1;
                hour_carry = (min_d == 4'd5) && (min_u == 4'd9);
            end
        end
        if (pulse_m) begin
            sec_n   = 6'd0;
            presc_n = '0;
        end

        if (pulse_h || hour_carry) begin
            if (hora_d == 4'd2 && hora_u == 4'd3) begin
                hd_n = 4'd0;
                hu_n = 4'd0;
            end else if (hora_u == 4'd9) begin
                hd_n = hora_d + 4'd1;
                hu_n = 4'd0;
            end else begin
                hu_n = hora_u + 4'd1;
            end
        end

        // dp_blink registered from the next prescaler value so it always matches presc.
        dp_n = (presc_n < PRE_HALF);
    end

    // Timekeeping state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc    <= '0;
            sec      <= 6'd0;
            hora_d   <= 4'd0;
            hora_u   <= 4'd0;
            min_d    <= 4'd0;
            min_u    <= 4'd0;
            dp_blink <= 1'b1;
            tick_min <= 1'b0;
        end else begin
            presc    <= presc_n;
            sec      <= sec_n;
            hora_d   <= hd_n;
            hora_u   <= hu_n;
            min_d    <= md_n;
            min_u    <= mu_n;
            dp_blink <= dp_n;
            tick_min <= tick_n;
        end
    end

endmodule

// File: tb/tb_reloj_bcd.sv
// tb_reloj_bcd: scoreboard bench for reloj_bcd with SEC_DIV = 4, SYNC_STAGES = 2.
module tb_reloj_bcd;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       btn_hora = 1'b0;
    logic       btn_min = 1'b0;
    logic [3:0] hora_d, hora_u, min_d, min_u;
    logic       dp_blink, tick_min;
    logic [15:0] digits;

    int n_cmp = 0;
    int n_err = 0;

    string       tag_q[$];
    logic [31:0] exp_q[$];

    reloj_bcd #(.SEC_DIV(4), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .btn_hora (btn_hora),
        .btn_min  (btn_min),
        .hora_d   (hora_d),
        .hora_u   (hora_u),
        .min_d    (min_d),
        .min_u    (min_u),
        .dp_blink (dp_blink),
        .tick_min (tick_min)
    );

    assign digits = {hora_d, hora_u, min_d, min_u};

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic observe(input logic [31:0] got);
        string       t;
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check_val("scoreboard_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check_val(t, got, e);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // which: 0 = btn_hora, 1 = btn_min
    task automatic press(input int which);
        @(negedge clk);
        if (which == 0) btn_hora = 1'b1; else btn_min = 1'b1;
        repeat (4) @(negedge clk);
        btn_hora = 1'b0;
        btn_min  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic preset(input int hh, input int mm);
        run = 1'b0;
        do_reset();
        repeat (hh) press(0);
        repeat (mm) press(1);
    endtask

    // Natural carry lands on edge 240 after run rises; a raw edge after edge 237 is applied on edge 240.
    task automatic aligned_press(input int which);
        @(negedge clk);
        run = 1'b1;
        repeat (237) @(posedge clk);
        @(negedge clk);
        if (which == 0) btn_hora = 1'b1; else btn_min = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        int bad;
        logic [15:0] frozen_d;
        logic        frozen_dp;

        // Reset state
        expect_val("rst_digits", 32'h0000);
        expect_val("rst_dp", 32'd1);
        expect_val("rst_tick", 32'd0);
        run = 1'b1;
        repeat (2) sample();
        observe(32'(digits));
        observe(32'(dp_blink));
        observe(32'(tick_min));

        // Free run for one minute from reset release
        for (int n = 1; n <= 8; n++) expect_val("s1_dp", 32'((n % 4) < 2));
        expect_val("s1_digits_239", 32'h0000);
        expect_val("s1_digits_240", 32'h0001);
        expect_val("s1_tick_240", 32'd1);
        expect_val("s1_tick_241", 32'd0);
        expect_val("s1_tick_count", 32'd1);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int n = 1; n <= 241; n++) begin
            sample();
            if (tick_min) pulses++;
            if (n <= 8) observe(32'(dp_blink));
            if (n == 239) observe(32'(digits));
            if (n == 240) begin
                observe(32'(digits));
                observe(32'(tick_min));
            end
            if (n == 241) observe(32'(tick_min));
        end
        observe(32'(pulses));

        // 23:59 -> 00:00 in a single edge
        preset(23, 59);
        expect_val("s2_preset", 32'h2359);
        expect_val("s2_intermediate", 32'd0);
        expect_val("s2_digits_240", 32'h0000);
        expect_val("s2_tick_240", 32'd1);
        expect_val("s2_tick_241", 32'd0);
        observe(32'(digits));
        @(negedge clk);
        run = 1'b1;
        bad = 0;
        for (int n = 1; n <= 241; n++) begin
            sample();
            if (n < 240 && digits != 16'h2359) bad++;
            if (n == 240) begin
                observe(32'(bad));
                observe(32'(digits));
                observe(32'(tick_min));
            end
            if (n == 241) observe(32'(tick_min));
        end

        // btn_min held at 00:59 with seconds mid-count
        preset(0, 59);
        expect_val("s3_dp_midsec", 32'd0);
        expect_val("s3_digits_after_hold", 32'h0000);
        expect_val("s3_tick_during_hold", 32'd0);
        expect_val("s3_dp_cleared", 32'd1);
        expect_val("s3_digits_239", 32'h0000);
        expect_val("s3_digits_240", 32'h0001);
        @(negedge clk);
        run = 1'b1;
        repeat (10) sample();
        observe(32'(dp_blink));
        @(negedge clk);
        run = 1'b0;
        btn_min = 1'b1;
        pulses = 0;
        for (int n = 0; n < 50; n++) begin
            sample();
            if (tick_min) pulses++;
        end
        @(negedge clk);
        btn_min = 1'b0;
        for (int n = 0; n < 5; n++) begin
            sample();
            if (tick_min) pulses++;
        end
        observe(32'(digits));
        observe(32'(pulses));
        observe(32'(dp_blink));
        @(negedge clk);
        run = 1'b1;
        for (int n = 1; n <= 240; n++) begin
            sample();
            if (n == 239 || n == 240) observe(32'(digits));
        end

        // btn_min aligned with natural minute carry at 12:34
        preset(12, 34);
        expect_val("s4_min_aligned", 32'h1235);
        expect_val("s4_min_tick_a", 32'd0);
        expect_val("s4_min_tick_b", 32'd0);
        aligned_press(1);
        observe(32'(digits));
        observe(32'(tick_min));
        sample();
        observe(32'(tick_min));

        // btn_hora aligned with natural hour carry at 09:59
        preset(9, 59);
        expect_val("s4_hour_aligned", 32'h1000);
        expect_val("s4_hour_tick", 32'd1);
        aligned_press(0);
        observe(32'(digits));
        observe(32'(tick_min));
        btn_hora = 1'b0;

        // run = 0 freezes time; 24 hour presses wrap back to 05:07
        preset(5, 7);
        expect_val("s5_dp_before", 32'd0);
        expect_val("s5_changes_frozen", 32'd0);
        expect_val("s5_digits_frozen", 32'h0507);
        expect_val("s5_digits_24h", 32'h0507);
        expect_val("s5_dp_24h", 32'd0);
        @(negedge clk);
        run = 1'b1;
        repeat (6) sample();
        observe(32'(dp_blink));
        @(negedge clk);
        run = 1'b0;
        sample();
        frozen_d  = digits;
        frozen_dp = dp_blink;
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            sample();
            if (digits != frozen_d || dp_blink != frozen_dp) bad++;
        end
        observe(32'(bad));
        observe(32'(digits));
        repeat (24) press(0);
        sample();
        observe(32'(digits));
        observe(32'(dp_blink));

        // Asynchronous reset mid-press at 17:42, button held across release
        preset(17, 42);
        expect_val("s6_preset", 32'h1742);
        expect_val("s6_async_digits", 32'h0000);
        expect_val("s6_async_dp", 32'd1);
        expect_val("s6_held_release", 32'h0000);
        expect_val("s6_after_unpress", 32'h0000);
        expect_val("s6_fresh_press", 32'h0100);
        observe(32'(digits));
        @(negedge clk);
        btn_hora = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        observe(32'(digits));
        observe(32'(dp_blink));
        @(negedge clk);
        reset = 1'b1;
        repeat (10) sample();
        observe(32'(digits));
        @(negedge clk);
        btn_hora = 1'b0;
        repeat (5) sample();
        observe(32'(digits));
        press(0);
        sample();
        observe(32'(digits));

        check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reloj_bcd.md
RELOJ_BCD -- requirements
Module: reloj_bcd

Interface
REQ-001 Parameter SEC_DIV, default 100_000_000: clk cycles per one-second tick, legal range >= 2.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth on button inputs, legal range >= 2.
REQ-003 clk  input  1  system clock (100 MHz board clock); all state SHALL change on its rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset; reset = 0 SHALL clear all state immediately, and release SHALL be synchronous to clk.
REQ-005 run  input  1  1 = timekeeping advances; 0 = prescaler and seconds frozen, set buttons still active.
REQ-006 btn_hora  input  1  asynchronous raw push-button: increment hours.
REQ-007 btn_min  input  1  asynchronous raw push-button: increment minutes.
REQ-008 hora_d  output  4  BCD tens of hour, 0..2.
REQ-009 hora_u  output  4  BCD units of hour, 0..9 (0..3 when hora_d = 2).
REQ-010 min_d  output  4  BCD tens of minute, 0..5.
REQ-011 min_u  output  4  BCD units of minute, 0..9.
REQ-012 dp_blink  output  1  1 during first half of each second, 0 during the second half (drives colon/dp).
REQ-013 tick_min  output  1  one-cycle pulse on every natural minute rollover.

Function
REQ-014 Prescaler SHALL count 0..SEC_DIV-1 while run = 1 and wrap to 0; one-second tick = cycle where count = SEC_DIV-1.
REQ-015 dp_blink SHALL be 1 while prescaler < SEC_DIV/2 (integer division), else 0.
REQ-016 Seconds counter (internal, 0..59, binary) SHALL increment on each tick and wrap 59 -> 0, generating a minute carry.
REQ-017 Minute carry SHALL advance min_u; min_u 9 -> 0 SHALL advance min_d; min_d:min_u 59 -> 00 SHALL generate an hour carry.
REQ-018 Hour carry SHALL advance hours; 09 -> 10, 19 -> 20, 23 -> 00 (24-hour format); no day carry exists.
REQ-019 All counter updates from one tick SHALL complete in the same clk edge, so digits never show an intermediate value (e.g. 23:59 -> 00:00 in one cycle).
REQ-020 tick_min SHALL assert in the cycle after the edge that updates minutes from a natural carry, and last exactly one cycle.
REQ-021 Each button SHALL pass through a SYNC_STAGES flip-flop synchroniser, then a rising-edge detector yielding a one-cycle press pulse; a held button yields exactly one pulse.
REQ-022 btn_min pulse SHALL increment minutes by one with wrap 59 -> 00 without hour carry, clear seconds and prescaler to 0, and not assert tick_min.
REQ-023 btn_hora pulse SHALL increment hours by one with wrap 23 -> 00, leaving minutes, seconds and prescaler unchanged.
REQ-024 If a btn_min pulse and a natural minute carry occur in the same cycle, minutes SHALL advance exactly once, no hour carry SHALL occur from the press, and tick_min SHALL not assert.
REQ-025 If a btn_hora pulse and a natural hour carry occur in the same cycle, hours SHALL advance exactly once.
REQ-026 Outputs SHALL be registered; digit outputs SHALL never hold a non-BCD or out-of-range value.

Reset
REQ-027 With reset = 0: hora_d = hora_u = min_d = min_u = 0, seconds = 0, prescaler = 0, dp_blink = 1, tick_min = 0, synchroniser and edge-detector flops = 0.
REQ-028 Reset asserted mid-operation or mid-press SHALL take effect without waiting for clk; a button held through reset release SHALL NOT produce a press pulse.

Verification (SEC_DIV = 4 unless stated)
REQ-029 Reset release, run = 1, 240 cycles -> digits read 00:01, tick_min pulsed once, dp_blink toggled 1,1,0,0 per second.
REQ-030 Preload via buttons to 23:59, run 60 ticks -> single-edge transition to 00:00 with tick_min = 1 one cycle, no intermediate value.
REQ-031 btn_min held 50 cycles at 00:59 -> exactly 00:00 (hours unchanged), seconds cleared, tick_min stays 0.
REQ-032 btn_min edge aligned to natural minute carry at 12:34 -> 12:35 only, tick_min = 0; btn_hora aligned to hour carry at 09:59 -> 10:00.
REQ-033 run = 0 for 100 cycles at 05:07 -> digits and dp_blink frozen; 24 btn_hora presses -> back to 05:07.
REQ-034 reset pulsed low between clk edges at 17:42 -> all outputs zero before next edge; button held across release -> no increment.
